// File: rtl/lcd_spi_writer_if.sv
// Byte-write handshake between the LCD sequencer mux and the SPI serialiser.
// Latency: n/a (signal bundle only).
// Backpressure: busy/wr_done tell the sequencer when the next word may be presented.
interface lcd_spi_writer_if;
  logic [8:0] wr_data;   // [8]=1 data, [8]=0 command; [7:0]=byte
  logic       en_write;  // level request, sampled only while the writer is idle
  logic       wr_done;   // one-cycle pulse once the byte has left the pins
  logic       busy;      // high whenever the writer is not idle

  // Sequencer side: presents words, watches completion.
  modport master (
    output wr_data,
    output en_write,
    input  wr_done,
    input  busy
  );

  // Writer side: consumes words, reports completion.
  modport slave (
    input  wr_data,
    input  en_write,
    output wr_done,
    output busy
  );
endinterface

// File: rtl/lcd_spi_writer.sv
// Serialises 9-bit {dc, byte} words MSB-first onto a 4-wire mode-0 SPI LCD bus.
// Latency: pins move 1 cycle after acceptance; wr_done at 17*CLK_DIV+1; period 17*CLK_DIV+2+GAP_CYCLES.
// Backpressure: en_write is only sampled in IDLE; words presented while busy are ignored.
module lcd_spi_writer #(
  parameter int CLK_DIV    = 2,  // SCLK half-period in sys clocks, 1..255
  parameter int GAP_CYCLES = 2   // CS-high idle cycles after wr_done, 1..15
) (
  input  logic            sys_clk_50MHz,
  input  logic            sys_rst,
  lcd_spi_writer_if.slave wr_if,
  output logic            lcd_cs,
  output logic            lcd_sclk,
  output logic            lcd_mosi,
  output logic            lcd_dc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;       // half-period divider, 0..CLK_DIV-1
  logic       phase_q, phase_d;   // 0 = SCLK low half, 1 = SCLK high half
  logic [2:0] bit_q, bit_d;       // bit index, 7 down to 0
  logic [3:0] gap_q, gap_d;       // CS-high gap counter
  logic [7:0] shreg_q, shreg_d;   // byte latched at acceptance
  logic       dc_q, dc_d;         // D/C latched at acceptance

  // Next-cycle pin values, decoded from the current state and registered below
  // so every pin comes straight off a flop.
  logic cs_d, sclk_d, mosi_d, done_d, busy_d;
  logic done_q, busy_q;

  logic div_wrap;
  assign div_wrap = (div_q == DIV_LAST);

  // State, counters and latched word.
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      dc_q    <= dc_d;
    end
  end

  // Next-state, counter sequencing and pin decode.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    dc_d    = dc_q;
    cs_d    = 1'b1;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (wr_if.en_write) begin
          shreg_d = wr_if.wr_data[7:0];
          dc_d    = wr_if.wr_data[8];
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = 3'd7;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // MOSI follows the bit index, which only steps when SCLK drops, so
        // data is stable for the whole low half before each rising edge.
        cs_d   = 1'b0;
        sclk_d = phase_q;
        mosi_d = shreg_q[bit_q];
        if (div_wrap) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_HOLD: begin
        // Keep CS low with bit0 on MOSI for one half-period of hold time.
        cs_d   = 1'b0;
        mosi_d = shreg_q[bit_q];
        if (div_wrap) begin
          div_d   = '0;
          state_d = ST_DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        gap_d   = '0;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        // Gives the sequencer time to advance its counter and data register.
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered pins and handshake outputs.
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      lcd_cs   <= 1'b1;
      lcd_sclk <= 1'b0;
      lcd_mosi <= 1'b0;
      lcd_dc   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      lcd_cs   <= cs_d;
      lcd_sclk <= sclk_d;
      lcd_mosi <= mosi_d;
      lcd_dc   <= dc_q;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_if.wr_done = done_q;
  assign wr_if.busy    = busy_q;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench for lcd_spi_writer: one instance at CLK_DIV=2, one at CLK_DIV=1.
// Latency: cycle n means the values seen after the n-th edge following acceptance edge T0.
// Backpressure: stimulus only presents words while the writer is idle or streaming.
module tb_lcd_spi_writer;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd_spi_writer_if if_a();
  lcd_spi_writer_if if_b();

  logic a_cs, a_sclk, a_mosi, a_dc;
  logic b_cs, b_sclk, b_mosi, b_dc;

  lcd_spi_writer #(.CLK_DIV(2), .GAP_CYCLES(2)) dut_a (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .wr_if         (if_a.slave),
    .lcd_cs        (a_cs),
    .lcd_sclk      (a_sclk),
    .lcd_mosi      (a_mosi),
    .lcd_dc        (a_dc)
  );

  lcd_spi_writer #(.CLK_DIV(1), .GAP_CYCLES(2)) dut_b (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .wr_if         (if_b.slave),
    .lcd_cs        (b_cs),
    .lcd_sclk      (b_sclk),
    .lcd_mosi      (b_mosi),
    .lcd_dc        (b_dc)
  );

  int n_checks;
  int n_errors;
  int cyc;
  int base;
  int viol;
  int upd_at;
  int widx;

  // Per-instance monitor state (index 0 = dut_a, 1 = dut_b).
  logic [7:0] cap[2];
  int         bits[2];
  int         done_cnt[2];
  int         first_rise[2];
  logic       sclk_prev[2];
  int         done_cyc[2][8];
  logic [7:0] byte_log[2][8];
  logic       dc_log[2][8];
  int         bits_log[2][8];

  logic [8:0] words[3] = '{9'h02A, 9'h100, 9'h19F};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon(input int d);
    cap[d]        = '0;
    bits[d]       = 0;
    done_cnt[d]   = 0;
    first_rise[d] = -1;
  endtask

  task automatic mon(input int d, input logic sclk, input logic mosi, input logic dc, input logic done);
    if (sclk && !sclk_prev[d]) begin
      cap[d] = {cap[d][6:0], mosi};
      bits[d]++;
      if (first_rise[d] < 0) first_rise[d] = cyc;
    end
    sclk_prev[d] = sclk;
    if (done) begin
      if (done_cnt[d] < 8) begin
        byte_log[d][done_cnt[d]] = cap[d];
        dc_log[d][done_cnt[d]]   = dc;
        bits_log[d][done_cnt[d]] = bits[d];
        done_cyc[d][done_cnt[d]] = cyc;
      end
      done_cnt[d]++;
      bits[d] = 0;
    end
  endtask

  // One cycle: step to the falling edge, then update both monitors.
  task automatic tick();
    @(negedge clk);
    cyc++;
    mon(0, a_sclk, a_mosi, a_dc, if_a.wr_done);
    mon(1, b_sclk, b_mosi, b_dc, if_b.wr_done);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    if_a.en_write = 1'b0;
    if_a.wr_data  = '0;
    if_b.en_write = 1'b0;
    if_b.wr_data  = '0;
    sclk_prev[0] = 1'b0;
    sclk_prev[1] = 1'b0;
    clr_mon(0);
    clr_mon(1);

    // Reset state
    repeat (3) tick();
    check_val("rst_cs",    a_cs, 1);
    check_val("rst_sclk",  a_sclk, 0);
    check_val("rst_mosi",  a_mosi, 0);
    check_val("rst_dc",    a_dc, 0);
    check_val("rst_done",  if_a.wr_done, 0);
    check_val("rst_busy",  if_a.busy, 0);
    check_val("rst_b_cs",  b_cs, 1);
    check_val("rst_b_busy", if_b.busy, 0);
    rst = 1'b0;
    tick();

    // Single command byte 0x11 at CLK_DIV=2
    clr_mon(0);
    if_a.wr_data  = 9'h011;
    if_a.en_write = 1'b1;
    base = cyc + 1;
    for (int n = 0; n <= 40; n++) begin
      tick();
      if (n == 0) check_val("t1_cs_c0", a_cs, 1);
      if (n == 1) begin
        check_val("t1_cs_c1", a_cs, 0);
        check_val("t1_dc_c1", a_dc, 0);
        if_a.en_write = 1'b0;
      end
      if (n == 34) check_val("t1_done_c34", if_a.wr_done, 0);
      if (n == 35) check_val("t1_cs_c35", a_cs, 1);
      if (n == 37) check_val("t1_busy_c37", if_a.busy, 1);
      if (n == 38) check_val("t1_busy_c38", if_a.busy, 0);
    end
    check_val("t1_first_rise", first_rise[0] - base, 3);
    check_val("t1_byte",       byte_log[0][0], 8'h11);
    check_val("t1_bits",       bits_log[0][0], 8);
    check_val("t1_done_cyc",   done_cyc[0][0] - base, 35);
    check_val("t1_done_cnt",   done_cnt[0], 1);

    // Data byte 0xA5 at CLK_DIV=1
    clr_mon(1);
    if_b.wr_data  = 9'h1A5;
    if_b.en_write = 1'b1;
    base = cyc + 1;
    for (int n = 0; n <= 25; n++) begin
      tick();
      if (n == 1) begin
        check_val("t2_dc_c1", b_dc, 1);
        if_b.en_write = 1'b0;
      end
      if (n == 20) check_val("t2_busy_c20", if_b.busy, 1);
      if (n == 21) check_val("t2_busy_c21", if_b.busy, 0);
    end
    check_val("t2_first_rise", first_rise[1] - base, 2);
    check_val("t2_byte",       byte_log[1][0], 8'hA5);
    check_val("t2_done_cyc",   done_cyc[1][0] - base, 18);
    check_val("t2_done_cnt",   done_cnt[1], 1);

    // Back-to-back stream of three words, data updated 2 cycles after each wr_done
    clr_mon(0);
    if_a.wr_data  = words[0];
    if_a.en_write = 1'b1;
    base   = cyc + 1;
    upd_at = -1;
    widx   = 1;
    for (int n = 0; n <= 130; n++) begin
      tick();
      if (if_a.wr_done) upd_at = cyc + 2;
      if (cyc == upd_at) begin
        if (widx < 3) if_a.wr_data = words[widx];
        else if_a.en_write = 1'b0;
        widx++;
      end
    end
    check_val("t3_done_cnt", done_cnt[0], 3);
    check_val("t3_byte0",    byte_log[0][0], 8'h2A);
    check_val("t3_byte1",    byte_log[0][1], 8'h00);
    check_val("t3_byte2",    byte_log[0][2], 8'h9F);
    check_val("t3_dc0",      dc_log[0][0], 0);
    check_val("t3_dc1",      dc_log[0][1], 1);
    check_val("t3_dc2",      dc_log[0][2], 1);
    check_val("t3_first_done", done_cyc[0][0] - base, 35);
    check_val("t3_gap01",    done_cyc[0][1] - done_cyc[0][0], 38);
    check_val("t3_gap12",    done_cyc[0][2] - done_cyc[0][1], 38);
    check_val("t3_busy_end", if_a.busy, 0);

    // Data changes and en_write drops mid-byte
    clr_mon(0);
    if_a.wr_data  = 9'h03C;
    if_a.en_write = 1'b1;
    base = cyc + 1;
    for (int n = 0; n <= 60; n++) begin
      tick();
      if (n == 5)  if_a.wr_data = 9'h0FF;
      if (n == 10) if_a.en_write = 1'b0;
    end
    check_val("t4_done_cnt", done_cnt[0], 1);
    check_val("t4_byte",     byte_log[0][0], 8'h3C);
    check_val("t4_dc",       dc_log[0][0], 0);
    check_val("t4_bits",     bits_log[0][0], 8);
    check_val("t4_no_more",  bits[0], 0);
    check_val("t4_busy",     if_a.busy, 0);

    // Reset in the middle of a byte
    clr_mon(0);
    if_a.wr_data  = 9'h155;
    if_a.en_write = 1'b1;
    base = cyc + 1;
    for (int n = 0; n <= 20; n++) begin
      tick();
      if (n == 1) if_a.en_write = 1'b0;
      if (n == 20) begin
        check_val("t5_cs_pre", a_cs, 0);
        check_val("t5_dc_pre", a_dc, 1);
        rst = 1'b1;
      end
    end
    tick();
    check_val("t5_cs",   a_cs, 1);
    check_val("t5_sclk", a_sclk, 0);
    check_val("t5_mosi", a_mosi, 0);
    check_val("t5_dc",   a_dc, 0);
    check_val("t5_busy", if_a.busy, 0);
    rst = 1'b0;
    repeat (50) tick();
    check_val("t5_no_done", done_cnt[0], 0);
    clr_mon(0);
    if_a.wr_data  = 9'h0C3;
    if_a.en_write = 1'b1;
    base = cyc + 1;
    for (int n = 0; n <= 40; n++) begin
      tick();
      if (n == 1) if_a.en_write = 1'b0;
    end
    check_val("t5_after_cnt",  done_cnt[0], 1);
    check_val("t5_after_byte", byte_log[0][0], 8'hC3);
    check_val("t5_after_dc",   dc_log[0][0], 0);
    check_val("t5_after_done", done_cyc[0][0] - base, 35);

    // Idle soak
    clr_mon(0);
    clr_mon(1);
    viol = 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (a_cs !== 1'b1 || a_sclk !== 1'b0 || if_a.wr_done !== 1'b0 || if_a.busy !== 1'b0) viol++;
      if (b_cs !== 1'b1 || b_sclk !== 1'b0 || if_b.wr_done !== 1'b0 || if_b.busy !== 1'b0) viol++;
    end
    check_val("t6_viol",     viol, 0);
    check_val("t6_done_a",   done_cnt[0], 0);
    check_val("t6_done_b",   done_cnt[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_spi_writer.md
Name: lcd_spi_writer

Overview:
Serialiser at the far end of the LCD init/draw byte interface. It accepts 9-bit words {dc, byte[7:0]} under the en_write/wr_done handshake and shifts each byte MSB-first onto a 4-wire SPI bus to the ST7789-class panel: CS, SCLK (mode 0), MOSI and D/C.
It sits between the init/draw sequencers (through the top-level mux) and the LCD pins. It pulses wr_done once per byte, and the sequencer advances its command counter on that pulse.

Parameters:
CLK_DIV, 2, SCLK half-period in sys clocks; SCLK = 50 MHz / (2*CLK_DIV); legal range 1..255; 0 is illegal.
GAP_CYCLES, 2, CS-high idle cycles after each wr_done before the next word is sampled; legal range 1..15. It covers the two-cycle sequencer latency (counter update, then data register update).

Ports:
sys_clk_50MHz  in   1  system clock, 50 MHz; the only clock.
sys_rst        in   1  synchronous reset, active-high.
wr_data        in   9  [8]=1 data, [8]=0 command; [7:0]=byte.
en_write       in   1  level request; sampled only in IDLE.
wr_done        out  1  one-cycle pulse when the byte has fully left the pins.
busy           out  1  high in every state except IDLE.
lcd_cs         out  1  chip select, active-low.
lcd_sclk       out  1  SPI clock, idles low (CPOL=0, CPHA=0).
lcd_mosi       out  1  serial data, MSB first.
lcd_dc         out  1  data/command select, equal to the latched wr_data[8].

Behaviour:
- All outputs are registered. On sys_rst high at a clock edge:
  - lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, wr_done=0, busy=0.
  - State goes to IDLE; the shift register and counters clear.
- States: IDLE -> SHIFT -> HOLD -> DONE -> GAP -> IDLE.
- IDLE:
  - cs=1, sclk=0.
  - If en_write=1 at edge T0: latch wr_data into shreg/dc and go to SHIFT.
  - From T0+1: cs=0, dc=latched[8], mosi=latched[7].
- SHIFT:
  - Lasts 16*CLK_DIV cycles, 8 bits of 2*CLK_DIV cycles each.
  - Per bit: first CLK_DIV cycles sclk=0 with mosi stable on the current bit; next CLK_DIV cycles sclk=1.
  - mosi moves to the next bit on the cycle sclk returns to 0.
  - The panel samples on the sclk rising edge; mosi is always stable at least CLK_DIV cycles before and during sclk high.
  - Counters: half-period divider (0..CLK_DIV-1) and bit index (7..0).
- HOLD: CLK_DIV cycles with cs=0, sclk=0, mosi holding bit0; gives CS-hold time.
- DONE: exactly 1 cycle with wr_done=1, cs=1, sclk=0.
- GAP: GAP_CYCLES cycles with cs=1, busy=1; then go to IDLE.
- Timing, with T0 = IDLE sample edge:
  - First sclk rise at T0+1+CLK_DIV.
  - wr_done high at T0+17*CLK_DIV+1.
  - IDLE re-entered at T0+17*CLK_DIV+2+GAP_CYCLES.
  - Default byte period is 38 cycles.
- Handshake and boundary rules:
  - wr_data and en_write are ignored outside IDLE. Changes to data mid-byte do not corrupt the byte in flight.
  - If en_write falls mid-byte, the byte still completes and wr_done still pulses.
  - If en_write is still high on the IDLE re-entry cycle, the next word starts immediately (back-to-back streaming).
  - If en_write is low in IDLE, outputs hold their idle values indefinitely.
  - Exactly one wr_done pulse per accepted word; wr_done never pulses without a prior acceptance.
  - lcd_dc is constant from T0+1 through the DONE cycle and keeps its value while idle.
  - sys_rst during any state aborts the byte: no wr_done, and pins return to idle values on the next edge.
  - A 76800-word stream is handled without internal counter overflow; there is no per-stream state.

Test Plan:
- Reset, then en_write=1 with wr_data=9'h011, default params:
  - dc=0 and cs low from cycle 1.
  - MOSI sampled at the 8 sclk rises reads 0x11; first rise at cycle 3.
  - wr_done is a single pulse at cycle 35; cs high at 35.
- wr_data=9'h1A5, CLK_DIV=1:
  - dc=1; sampled bits read 1010_0101.
  - wr_done at cycle 18; next IDLE at cycle 20.
- Stream of 3 words 9'h02A, 9'h100, 9'h19F with en_write held high; the stimulus updates wr_data 2 cycles after each wr_done:
  - Captured bytes are exactly 2A/00/9F with dc 0/1/1.
  - Three wr_done pulses, 38 cycles apart.
- en_write dropped at cycle 10 of a byte, with wr_data changed to 9'h0FF at cycle 5:
  - The original byte is transmitted intact and wr_done still fires.
  - No second byte starts.
- sys_rst asserted at cycle 20 of a byte:
  - Next edge gives cs=1, sclk=0, mosi=0, dc=0, busy=0.
  - No wr_done; a subsequent word transmits correctly.
- Idle soak of 1000 cycles with en_write=0:
  - cs stays 1, sclk stays 0, no wr_done, busy=0.
